mem_copy_dma: RTL and testbench

- Bus-master block-copy engine for the 8-bit data memory.
- Acts as the initiator side of the data memory port, driving rd/wr/address/write-data and consuming read data.
- On a start command it copies `length` bytes from `src_addr` to `dst_addr`, one byte at a time. It runs as a read-then-write sequence, with the byte buffered internally between the two.
- Sits beside the CPU as a memory-port master; the top level muxes it onto the memory port while `busy`.

---
 rtl/mem_copy_dma.sv | 152 +++++++++++++++
 tb/tb_mem_copy_dma.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_dma.sv
// Bus-master block copy: moves `length` bytes from src_addr to dst_addr, one read then one write per byte.
// Latency: first READ one cycle after an accepted start; done pulses 2*length+1 cycles after the start edge.
// Backpressure: none; the memory is assumed single-cycle, so the engine never stalls.
//
// Ports:
//   clk, rst_n                  clock and synchronous active-low reset
//   start, abort                command strobe (IDLE only) and early termination (READ/WRITE only)
//   src_addr, dst_addr, length  copy operands, latched on an accepted start
//   mem_rd, mem_wr, mem_add,    memory-port master side; outputs are decoded from registered
//   mem_wdata, mem_rdata        state only, mem_rdata is consumed at the end of READ
//   busy, done, xfer_count      status: active copy, one-cycle completion pulse, bytes written
module mem_copy_dma #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_add,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] xfer_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] byte_buf;

  // The copy finishes on the write whose post-increment index reaches the latched length.
  logic last_byte;
  assign last_byte = ((idx + 1'b1) == len_q);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          // Zero-length commands go straight to completion with no memory access.
          state_nxt = (length != '0) ? READ : DONE;
        end
      end
      READ: begin
        state_nxt = abort ? DONE : WRITE;
      end
      WRITE: begin
        // An abort here still lets this write commit; it only suppresses further bytes.
        state_nxt = (abort || last_byte) ? DONE : READ;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output decode: only state and registered operands/buffer, so nothing here
  // depends combinationally on start or abort.
  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_add   = '0;
    mem_wdata = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      READ: begin
        mem_rd  = 1'b1;
        mem_add = src_q + idx;
        busy    = 1'b1;
      end
      WRITE: begin
        mem_wr    = 1'b1;
        mem_add   = dst_q + idx;
        mem_wdata = byte_buf;
        busy      = 1'b1;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Datapath: operand latches, byte index, read buffer and transfer counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      idx        <= '0;
      byte_buf   <= '0;
      xfer_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            src_q      <= src_addr;
            dst_q      <= dst_addr;
            len_q      <= length;
            idx        <= '0;
            xfer_count <= '0;
          end
        end
        READ: begin
          // An aborted read never reaches WRITE, so its data is dropped.
          if (!abort) begin
            byte_buf <= mem_rdata;
          end
        end
        WRITE: begin
          idx        <= idx + 1'b1;
          xfer_count <= xfer_count + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_dma.sv
module tb_mem_copy_dma;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] src_addr;
  logic [7:0] dst_addr;
  logic [7:0] length;
  logic       mem_rd;
  logic       mem_wr;
  logic [7:0] mem_add;
  logic [7:0] mem_wdata;
  wire  [7:0] mem_rdata;
  logic       busy;
  logic       done;
  logic [7:0] xfer_count;

  int vectors    = 0;
  int miscompares = 0;

  // Memory as seen by the DUT, and an independent byte-wise copy model.
  logic [7:0] mem [256];
  logic [7:0] mm  [256];

  always #5 clk = ~clk;

  assign mem_rdata = mem_rd ? mem[mem_add] : 8'hzz;

  always @(posedge clk) begin
    if (mem_wr) mem[mem_add] = mem_wdata;
  end

  mem_copy_dma #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .length     (length),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_add    (mem_add),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .done       (done),
    .xfer_count (xfer_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one copy from the IDLE state, checking every cycle against the copy model.
  // abort_at: copy cycle (1-based) in which abort is held high, 0 for none.
  // glitch: pulse start with other operands mid-copy and in the DONE cycle.
  task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                          input int abort_at, input bit glitch, input string nm);
    logic [7:0] b;
    logic [7:0] ea;
    int         c;
    int         k;
    int         wrote;
    int         bad;
    bit         fin;
    for (int i = 0; i < 256; i++) mm[i] = mem[i];
    src_addr = s; dst_addr = d; length = l; abort = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    b = 8'h00; wrote = 0; c = 1; fin = (l == 8'd0);
    while (!fin && c <= 600) begin
      k = (c - 1) / 2;
      if (glitch && c == 2) begin
        start = 1'b1; src_addr = 8'h55; dst_addr = 8'hAA; length = 8'h09;
      end else begin
        start = 1'b0;
      end
      abort = (c == abort_at);
      vectors++;
      if ({busy, done} !== 2'b10)
        begin miscompares++; $display("FAIL %s_status c=%0d got busy,done=%b%b want 10", nm, c, busy, done); end
      if ((c % 2) == 1) begin
        ea = s + 8'(k);
        vectors++;
        if ({mem_rd, mem_wr, mem_add, mem_wdata} !== {2'b10, ea, 8'h00})
          begin miscompares++; $display("FAIL %s_read c=%0d got rd=%b wr=%b add=%h wd=%h want rd=1 wr=0 add=%h wd=00", nm, c, mem_rd, mem_wr, mem_add, mem_wdata, ea); end
        b = mm[ea];
        if (abort) fin = 1'b1;
      end else begin
        ea = d + 8'(k);
        vectors++;
        if ({mem_rd, mem_wr, mem_add, mem_wdata} !== {2'b01, ea, b})
          begin miscompares++; $display("FAIL %s_write c=%0d got rd=%b wr=%b add=%h wd=%h want rd=0 wr=1 add=%h wd=%h", nm, c, mem_rd, mem_wr, mem_add, mem_wdata, ea, b); end
        mm[ea] = b;
        wrote++;
        if (abort || (k + 1) == int'(l)) fin = 1'b1;
      end
      tick();
      c++;
    end
    abort = 1'b0;
    vectors++;
    if (c > 600)
      begin miscompares++; $display("FAIL %s_timeout got %0d cycles want done", nm, c); end
    if (glitch) begin
      start = 1'b1; src_addr = 8'h66; dst_addr = 8'h77; length = 8'h02;
    end
    vectors++;
    if ({busy, done, mem_rd, mem_wr, mem_add, mem_wdata} !== {4'b0100, 16'h0000})
      begin miscompares++; $display("FAIL %s_done got busy=%b done=%b rd=%b wr=%b add=%h wd=%h want done only", nm, busy, done, mem_rd, mem_wr, mem_add, mem_wdata); end
    vectors++;
    if (xfer_count !== 8'(wrote))
      begin miscompares++; $display("FAIL %s_count got %0d want %0d", nm, xfer_count, wrote); end
    tick();
    start = 1'b0;
    vectors++;
    if ({busy, done, xfer_count} !== {2'b00, 8'(wrote)})
      begin miscompares++; $display("FAIL %s_idle got busy=%b done=%b cnt=%0d want 0 0 %0d", nm, busy, done, xfer_count, wrote); end
    tick();
    vectors++;
    if ({busy, done, mem_rd, mem_wr} !== 4'b0000)
      begin miscompares++; $display("FAIL %s_stay_idle got busy=%b done=%b rd=%b wr=%b want 0000", nm, busy, done, mem_rd, mem_wr); end
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== mm[i]) bad++;
    vectors++;
    if (bad != 0)
      begin miscompares++; $display("FAIL %s_memory got %0d differing bytes want 0", nm, bad); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; abort = 1'b0;
    src_addr = 8'h10; dst_addr = 8'h20; length = 8'h04;
    tick(); tick();
    vectors++;
    if ({mem_rd, mem_wr, mem_add, mem_wdata, busy, done, xfer_count} !== 28'h0)
      begin miscompares++; $display("FAIL reset_outputs got rd=%b wr=%b add=%h wd=%h busy=%b done=%b cnt=%h want all 0", mem_rd, mem_wr, mem_add, mem_wdata, busy, done, xfer_count); end
    start = 1'b0; rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({mem_rd, mem_wr, busy, done} !== 4'b0000)
        begin miscompares++; $display("FAIL reset_release c=%0d got rd=%b wr=%b busy=%b done=%b want 0000", i, mem_rd, mem_wr, busy, done); end
    end
  endtask

  task automatic test_basic_copy();
    mem[8'h10] = 8'hA5; mem[8'h11] = 8'h3C; mem[8'h12] = 8'hFF;
    mem[8'h80] = 8'h00; mem[8'h81] = 8'h00; mem[8'h82] = 8'h00;
    run_copy(8'h10, 8'h80, 8'd3, 0, 1'b0, "basic");
    vectors++;
    if ({mem[8'h80], mem[8'h81], mem[8'h82]} !== 24'hA53CFF)
      begin miscompares++; $display("FAIL basic_dest got %h%h%h want a53cff", mem[8'h80], mem[8'h81], mem[8'h82]); end
    vectors++;
    if (xfer_count !== 8'd3)
      begin miscompares++; $display("FAIL basic_xfer got %0d want 3", xfer_count); end
  endtask

  task automatic test_zero_length();
    run_copy(8'h30, 8'h40, 8'd0, 0, 1'b0, "zero");
    vectors++;
    if (xfer_count !== 8'd0)
      begin miscompares++; $display("FAIL zero_xfer got %0d want 0", xfer_count); end
  endtask

  task automatic test_wrap();
    mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33; mem[8'h01] = 8'h44;
    run_copy(8'hFE, 8'h01, 8'd4, 0, 1'b0, "wrap");
    vectors++;
    if ({mem[8'h01], mem[8'h02], mem[8'h03], mem[8'h04]} !== 32'h11223311)
      begin miscompares++; $display("FAIL wrap_dest got %h%h%h%h want 11223311", mem[8'h01], mem[8'h02], mem[8'h03], mem[8'h04]); end
  endtask

  task automatic test_abort();
    for (int i = 0; i < 5; i++) mem[8'hC0 + 8'(i)] = 8'h00;
    run_copy(8'h50, 8'hC0, 8'd5, 4, 1'b0, "abort_wr");
    vectors++;
    if ({xfer_count, mem[8'hC2], mem[8'hC3], mem[8'hC4]} !== 32'h02000000)
      begin miscompares++; $display("FAIL abort_wr_tail got cnt=%0d %h%h%h want 2 000000", xfer_count, mem[8'hC2], mem[8'hC3], mem[8'hC4]); end
    run_copy(8'h60, 8'hD0, 8'd5, 5, 1'b0, "abort_rd");
    vectors++;
    if (xfer_count !== 8'd2)
      begin miscompares++; $display("FAIL abort_rd_xfer got %0d want 2", xfer_count); end
    run_copy(8'h70, 8'hE0, 8'd2, 4, 1'b0, "abort_last");
  endtask

  task automatic test_back_to_back();
    run_copy(8'h20, 8'hA0, 8'd4, 0, 1'b1, "glitch");
    run_copy(8'h24, 8'hA8, 8'd2, 0, 1'b0, "followup");
  endtask

  task automatic test_reset_mid_write();
    src_addr = 8'h10; dst_addr = 8'h90; length = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    vectors++;
    if ({mem_rd, mem_wr} !== 2'b01)
      begin miscompares++; $display("FAIL rstmid_in_write got rd=%b wr=%b want 01", mem_rd, mem_wr); end
    rst_n = 1'b0;
    tick();
    vectors++;
    if ({mem_rd, mem_wr, mem_add, mem_wdata, busy, done, xfer_count} !== 28'h0)
      begin miscompares++; $display("FAIL rstmid_outputs got rd=%b wr=%b add=%h wd=%h busy=%b done=%b cnt=%h want all 0", mem_rd, mem_wr, mem_add, mem_wdata, busy, done, xfer_count); end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({mem_rd, mem_wr, busy, done} !== 4'b0000)
        begin miscompares++; $display("FAIL rstmid_quiet c=%0d got rd=%b wr=%b busy=%b done=%b want 0000", i, mem_rd, mem_wr, busy, done); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'((i * 37 + 11) ^ 8'h5A);
    test_reset();
    test_basic_copy();
    test_zero_length();
    test_wrap();
    test_abort();
    test_back_to_back();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
